// File: rtl/pipe_pkg.sv
// Shared constants for elastic pipeline-stage registers.
// Occupancy encoding, default stall-counter width, and payload widths
// per stage boundary so callers size their concatenated data buses consistently.
package pipe_pkg;

  // Occupancy values double as the skid-register state encoding.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int DEFAULT_CNT_W = 16;

  // Per-field widths of the datapath.
  localparam int INSTR_W    = 32;
  localparam int PC_W       = 32;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // Payload widths per stage boundary (sum of the concatenated fields).
  // F/D: Instr, PC+8
  localparam int FD_W = INSTR_W + PC_W;
  // D/E: Instr, RS value, RT value, imm, PC+8
  localparam int DE_W = INSTR_W + 3 * DATA_W + PC_W;
  // E/M: Instr, ALU result, RT value, PC+8, A3
  localparam int EM_W = INSTR_W + 2 * DATA_W + PC_W + REG_ADDR_W;
  // M/W: Instr, ALU result, DM data, PC+8, A3
  localparam int MW_W = INSTR_W + 2 * DATA_W + PC_W + REG_ADDR_W;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } occ_state_e;

endpackage

// File: rtl/pipe_stall_ctr.sv
// Saturating stall-cycle counter shared by stall-aware pipeline blocks.
// Latency: count reflects an inc one cycle after the edge it was sampled on.
// Backpressure: none; counts while inc is high, sticks at all-ones, clr wins over inc.
// Ports: clk, clr (sync clear), inc (count enable), cnt (current count).
module pipe_stall_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register: main entry plus one skid entry, FIFO order.
// Latency: 1 cycle from push into an empty stage to out_valid/out_data.
// Backpressure: in_ready is registered (!skid full); skid absorbs one in-flight push.
// Ports: clk, reset (sync, active-high), flush (sync kill), in_valid/in_ready/in_data
// upstream handshake, out_valid/out_ready/out_data downstream handshake,
// occupancy (0..2 entries held), stall_cycles (saturating back-pressure count).
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int               CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  occ_state_e       state;
  logic [WIDTH-1:0] skid_data;
  logic             push;
  logic             pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = state;

  // out_valid tracks "main entry valid" and in_ready tracks "skid entry empty";
  // both are kept as flops alongside the state so no output depends
  // combinationally on the handshake inputs.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= ST_EMPTY;
      out_data  <= FLUSH_VAL;
      skid_data <= FLUSH_VAL;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            out_data <= in_data;
          end else if (push) begin
            // Downstream stalled while upstream had a beat in flight.
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= ST_FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            out_data  <= skid_data;
            skid_data <= FLUSH_VAL;
            in_ready  <= 1'b1;
            state     <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // A flush cycle is not counted as a stall; reset clears the count.
  pipe_stall_ctr #(
    .CNT_W (CNT_W)
  ) u_stall_ctr (
    .clk (clk),
    .clr (reset),
    .inc (out_valid && !out_ready && !flush),
    .cnt (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam int               WIDTH = 16;
  localparam logic [WIDTH-1:0] FV    = 16'h5A5A;
  localparam int               CW    = 4;
  localparam int               CMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [1:0]       occupancy;
  logic [CW-1:0]    stall_cycles;

  int vectors = 0;
  int errors  = 0;

  // Reference model: a queue of held payloads (head = oldest) and a stall count.
  logic [WIDTH-1:0] mq[$];
  int               mcnt = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH     (WIDTH),
    .FLUSH_VAL (FV),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  // Drive one cycle of inputs, advance the model by the same cycle, then
  // settle 1 time unit past the clock edge so outputs are sampled stably.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [WIDTH-1:0] d, input logic ordy);
    bit can_push;
    bit do_pop;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    can_push = iv && (mq.size() < 2);
    do_pop   = (mq.size() > 0) && ordy;
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if ((mq.size() > 0) && !ordy && (mcnt < CMAX)) mcnt++;
      if (do_pop) void'(mq.pop_front());
      if (can_push) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 16'h0, 0);
    step(1, 1, 1, 16'h1234, 1);
    step(0, 0, 0, 16'h0, 1);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== FV) begin errors++; $display("FAIL reset_out_data: got %h want %h", out_data, FV); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    vectors++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_stream;
    logic [WIDTH-1:0] vals [3];
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, vals[i], 1);
      vectors++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin errors++; $display("FAIL stream_data[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_data, vals[i]); end
      vectors++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_occ[%0d]: got occ=%0d rdy=%b want occ=1 rdy=1", i, occupancy, in_ready); end
    end
    step(0, 0, 0, 16'h0, 1);
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_backpressure;
    int base;
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h000A, 0);
    vectors++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 16'h000A || stall_cycles !== 4'd0) begin errors++; $display("FAIL bp_first: got occ=%0d rdy=%b d=%h st=%0d want occ=1 rdy=1 d=000a st=0", occupancy, in_ready, out_data, stall_cycles); end
    step(0, 0, 1, 16'h000B, 0);
    vectors++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h000A || stall_cycles !== 4'd1) begin errors++; $display("FAIL bp_full: got occ=%0d rdy=%b d=%h st=%0d want occ=2 rdy=0 d=000a st=1", occupancy, in_ready, out_data, stall_cycles); end
    base = 1;
    // Upstream keeps offering a beat that must not be accepted while full.
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, 16'h00EE, 0);
      vectors++; if (stall_cycles !== 4'(base + i) || out_data !== 16'h000A || occupancy !== 2'd2) begin errors++; $display("FAIL bp_hold[%0d]: got st=%0d d=%h occ=%0d want st=%0d d=000a occ=2", i, stall_cycles, out_data, occupancy, base + i); end
    end
    step(0, 0, 0, 16'h0, 1);
    vectors++; if (out_valid !== 1'b1 || out_data !== 16'h000B || occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_b: got v=%b d=%h occ=%0d rdy=%b want v=1 d=000b occ=1 rdy=1", out_valid, out_data, occupancy, in_ready); end
    vectors++; if (stall_cycles !== 4'd4) begin errors++; $display("FAIL bp_stall_kept: got %0d want 4", stall_cycles); end
    step(0, 0, 0, 16'h0, 1);
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush;
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h000A, 0);
    step(0, 0, 1, 16'h000B, 0);
    step(0, 1, 1, 16'h000C, 0);
    vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== FV) begin errors++; $display("FAIL flush_full: got occ=%0d v=%b rdy=%b d=%h want occ=0 v=0 rdy=1 d=%h", occupancy, out_valid, in_ready, out_data, FV); end
    vectors++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL flush_stall_kept: got %0d want 1", stall_cycles); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 16'h0, 1);
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_c[%0d]: got v=%b d=%h want v=0", i, out_valid, out_data); end
    end
    // Flush in EMPTY while in_ready reads 1: the offered beat is dropped.
    step(0, 1, 1, 16'h0077, 1);
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_empty_push: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    // A payload equal to FLUSH_VAL is ordinary valid data.
    step(0, 0, 1, FV, 0);
    vectors++; if (out_valid !== 1'b1 || out_data !== FV || occupancy !== 2'd1) begin errors++; $display("FAIL flushval_data: got v=%b d=%h occ=%0d want v=1 d=%h occ=1", out_valid, out_data, occupancy, FV); end
  endtask

  task automatic test_saturation;
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'h0042, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 16'h0, 0);
      vectors++; if (stall_cycles !== 4'((i < CMAX) ? i : CMAX)) begin errors++; $display("FAIL sat[%0d]: got %0d want %0d", i, stall_cycles, (i < CMAX) ? i : CMAX); end
    end
    step(1, 0, 0, 16'h0, 0);
    vectors++; if (stall_cycles !== '0 || occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL sat_reset: got st=%0d occ=%0d v=%b want 0 0 0", stall_cycles, occupancy, out_valid); end
  endtask

  task automatic test_random;
    logic rst, fl, iv, ordy;
    logic [WIDTH-1:0] d;
    step(1, 0, 0, 16'h0, 0);
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = WIDTH'($urandom);
      step(rst, fl, iv, d, ordy);
      vectors++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, mq.size() > 0); end
      vectors++; if (occupancy !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", i, occupancy, mq.size()); end
      vectors++; if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, mq.size() < 2); end
      vectors++; if (stall_cycles !== 4'(mcnt)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, stall_cycles, mcnt); end
      if (mq.size() > 0) begin
        vectors++; if (out_data !== mq[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, out_data, mq[0]); end
      end else if (rst || fl) begin
        vectors++; if (out_data !== FV) begin errors++; $display("FAIL rnd_flushval[%0d]: got %h want %h", i, out_data, FV); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
